ccg_truth_table_capture: RTL
============================

Name: ccg_truth_table_capture

Overview:
- Sequential reader for the generated combinational benchmark circuits (4-input, 6-output random gate netlists).
- Drives the circuit-under-test inputs through all 2^N_IN vectors and samples its outputs after a settle delay.
- Streams one packed truth-table column per output over a valid/ready port, tagged with constant and duplicate flags.
- Sits between the netlist instance and the dataset label writer and functional checker.

Parameters:
N_IN, 4, number of circuit inputs; vector count is 2^N_IN
N_OUT, 6, number of circuit outputs; one emitted column each
SETTLE, 1, cycles vec_o is held before resp_i is sampled (>=1)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to capture; honoured only in IDLE
busy  out  1  high from the cycle after an accepted start until the last column handshake completes
vec_o  out  N_IN  input vector driven to the circuit under test
resp_i  in  N_OUT  circuit outputs; bit j = output j+1
out_valid  out  1  column available
out_ready  in  1  consumer accepts the column
out_idx  out  clog2(N_OUT)  output index of the current column
out_table  out  2^N_IN  bit k = resp_i[out_idx] sampled while vec_o==k
out_const  out  1  column all-0 or all-1
out_dup  out  1  column equals an earlier column (lower index)
out_dup_idx  out  clog2(N_OUT)  lowest earlier matching index; 0 when out_dup=0
done  out  1  single-cycle pulse after the final column handshake

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - All outputs 0: vec_o, busy, out_valid, out_idx, out_table, flags, done.
  - Table storage and counters are cleared.
- IDLE:
  - start=1 -> APPLY at the next edge; busy=1, vec_o=0, settle count=0.
  - start while not IDLE is ignored; it is neither queued nor does it restart a capture.
- APPLY:
  - vec_o holds value k for exactly SETTLE cycles.
  - At the edge ending the SETTLE-th cycle, the FSM stores resp_i into bit k of all N_OUT columns.
  - k<2^N_IN-1: vec_o increments to k+1 at that same edge.
  - k=2^N_IN-1: go to SCAN; vec_o returns to 0.
  - Capture phase lasts 2^N_IN*SETTLE cycles (16 with defaults).
- SCAN: one cycle per column j=0..N_OUT-1.
  - const[j] = (column == 0) or (column == all-ones).
  - Column j is compared against columns 0..j-1; the lowest match index is recorded.
  - After N_OUT cycles, go to EMIT with out_idx=0.
- EMIT:
  - out_valid=1; out_idx, out_table and flags stay stable while out_valid && !out_ready.
  - Handshake (valid && ready at an edge) advances out_idx.
  - After the handshake with out_idx=N_OUT-1: out_valid=0, busy=0, done=1 for one cycle, back to IDLE.
  - out_valid is never dropped without a handshake.
- Minimum back-to-back throughput is one column per cycle with out_ready held high.
- Reset mid-operation (any state): immediate return to IDLE with reset values; partial table discarded, no done pulse.
- Width rules: vec_o counter is N_IN+1 bits internally to detect wrap; index widths are clog2(N_OUT), minimum 1.

Decomposition:
- Package ccg_capture_pkg holds:
  - state enum IDLE/APPLY/SCAN/EMIT
  - default N_IN, N_OUT, SETTLE constants
  - a localparam function for vector count
- One sub-module, ccg_column_scan, is natural.
  - Inputs: the column array and j.
  - Outputs: const flag, dup flag and dup index.
  - Combinational compare plus registered result; keeps the main FSM small.

Test Plan:
- Identity loopback: resp_i={0,1,vec[1]&vec[0],0,vec[1],vec[0]}, N_IN=4.
  - Columns 0..5 = 0xAAAA, 0xCCCC, 0x0000, 0x8888, 0xFFFF, 0x0000.
  - out_const=1 on idx 2, 4, 5.
  - idx 5: out_dup=1, out_dup_idx=2.
  - All other columns out_dup=0.
- Timing, SETTLE=1: start at cycle 0.
  - vec_o=0 at cycle 1, vec_o=15 at cycle 16.
  - First out_valid at cycle 23 (16 capture + 6 scan cycles).
  - With out_ready=1, done pulses at cycle 29.
- SETTLE=3 with resp_i=vec_o[3:0]^6'h3F path delayed 2 cycles: table still correct (0x5555 for bit 0 inverted); capture lasts 48 cycles.
- Backpressure: out_ready low 5 cycles on idx 3 -> idx 3 data/flags stable all 5 cycles, no column skipped, done only after idx 5 accepted.
- start pulsed during APPLY and EMIT -> no restart; exactly 6 columns and one done. Start in the cycle after done -> new capture begins.
- rst asserted at vec_o=9 -> same-cycle async clear: busy=0, vec_o=0, out_valid=0. A subsequent start yields a full, correct 16-vector table.

Source files
------------

// File: rtl/ccg_capture_pkg.sv
// Shared types and sizing helpers for the truth-table capture block.
package ccg_capture_pkg;

  localparam int N_IN_DEF   = 4;
  localparam int N_OUT_DEF  = 6;
  localparam int SETTLE_DEF = 1;

  typedef enum logic [1:0] {IDLE, APPLY, SCAN, EMIT} state_e;

  // Number of input vectors swept for an n_in-input circuit.
  function automatic int vec_count(input int n_in);
    return 1 << n_in;
  endfunction

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ccg_truth_table_capture_if.sv
// Column stream from the capture block to the label writer / checker.
interface ccg_truth_table_capture_if import ccg_capture_pkg::*; #(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF
);
  localparam int NV = vec_count(N_IN);
  localparam int IW = idx_w(N_OUT);

  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic [NV-1:0] out_table;
  logic          out_const;
  logic          out_dup;
  logic [IW-1:0] out_dup_idx;

  modport master (
    output out_valid, out_idx, out_table, out_const, out_dup, out_dup_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_idx, out_table, out_const, out_dup, out_dup_idx,
    output out_ready
  );
endinterface

// File: rtl/ccg_truth_table_capture_column_scan.sv
// Classifies one column per enabled cycle (constant / duplicate of a
// lower-indexed column) and keeps the per-column results.
module ccg_column_scan #(
  parameter int N_OUT = 6,
  parameter int NV    = 16,
  parameter int IW    = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [N_OUT-1:0][NV-1:0]      cols,
  input  logic [IW-1:0]                 j,
  output logic [N_OUT-1:0]              const_v,
  output logic [N_OUT-1:0]              dup_v,
  output logic [N_OUT-1:0][IW-1:0]      dup_idx_v
);
  logic [NV-1:0] cur;
  logic          is_const;
  logic          is_dup;
  logic [IW-1:0] dup_idx;

  // Compare column j with every lower column; walk downward so the lowest match wins.
  always_comb begin
    cur      = cols[j];
    is_const = (cur == '0) || (cur == '1);
    is_dup   = 1'b0;
    dup_idx  = '0;
    for (int i = N_OUT - 1; i >= 0; i--) begin
      if ((IW'(i) < j) && (cols[i] == cur)) begin
        is_dup  = 1'b1;
        dup_idx = IW'(i);
      end
    end
  end

  // Record the classification of column j.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      const_v   <= '0;
      dup_v     <= '0;
      dup_idx_v <= '0;
    end else if (en) begin
      const_v[j]   <= is_const;
      dup_v[j]     <= is_dup;
      dup_idx_v[j] <= dup_idx;
    end
  end
endmodule

// File: rtl/ccg_truth_table_capture.sv
// Sweeps all input vectors of a combinational circuit, captures its truth
// table, classifies each output column, then streams the columns out.
module ccg_truth_table_capture import ccg_capture_pkg::*; #(
  parameter int N_IN   = N_IN_DEF,
  parameter int N_OUT  = N_OUT_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic [N_IN-1:0]            vec_o,
  input  logic [N_OUT-1:0]           resp_i,
  ccg_truth_table_capture_if.master  col,
  output logic                       done
);
  localparam int NV = vec_count(N_IN);
  localparam int IW = idx_w(N_OUT);
  localparam int SW = idx_w(SETTLE);
  localparam logic [IW-1:0] LAST_IDX    = IW'(N_OUT - 1);
  localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE - 1);

  state_e                   state, state_nxt;
  logic [N_IN:0]            vec_cnt;   // extra MSB flags the wrap past the last vector
  logic [N_IN:0]            vec_inc;
  logic                     last_vec;
  logic [SW-1:0]            settle_cnt;
  logic [IW-1:0]            scan_j;
  logic [IW-1:0]            emit_idx;
  logic [N_OUT-1:0][NV-1:0] cols;
  logic                     sample;
  logic                     scan_en;
  logic                     hs;
  logic [N_OUT-1:0]         const_v, dup_v;
  logic [N_OUT-1:0][IW-1:0] dup_idx_v;

  assign vec_inc  = vec_cnt + 1'b1;
  assign last_vec = vec_inc[N_IN];
  assign vec_o    = vec_cnt[N_IN-1:0];
  assign hs       = col.out_valid && col.out_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: start only counts in IDLE, so it cannot queue or restart.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)                          state_nxt = APPLY;
      APPLY:   if (sample && last_vec)             state_nxt = SCAN;
      SCAN:    if (scan_j == LAST_IDX)             state_nxt = EMIT;
      EMIT:    if (hs && (emit_idx == LAST_IDX))   state_nxt = IDLE;
      default:                                     state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs and enables.
  always_comb begin
    busy          = (state != IDLE);
    col.out_valid = (state == EMIT);
    sample        = (state == APPLY) && (settle_cnt == LAST_SETTLE);
    scan_en       = (state == SCAN);
  end

  // Vector/settle/scan/emit counters and the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_cnt    <= '0;
      settle_cnt <= '0;
      scan_j     <= '0;
      emit_idx   <= '0;
      done       <= 1'b0;
    end else begin
      done <= hs && (emit_idx == LAST_IDX);
      if (state == IDLE) begin
        vec_cnt    <= '0;
        settle_cnt <= '0;
      end else if (state == APPLY) begin
        if (sample) begin
          settle_cnt <= '0;
          vec_cnt    <= last_vec ? '0 : vec_inc;
        end else begin
          settle_cnt <= settle_cnt + 1'b1;
        end
      end
      if (scan_en) scan_j   <= (scan_j == LAST_IDX)   ? '0 : scan_j + 1'b1;
      if (hs)      emit_idx <= (emit_idx == LAST_IDX) ? '0 : emit_idx + 1'b1;
    end
  end

  // Capture every output into bit k of its column at the end of the settle window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cols <= '0;
    end else if (sample) begin
      for (int j = 0; j < N_OUT; j++) cols[j][vec_o] <= resp_i[j];
    end
  end

  ccg_column_scan #(.N_OUT(N_OUT), .NV(NV), .IW(IW)) u_scan (
    .clk       (clk),
    .rst       (rst),
    .en        (scan_en),
    .cols      (cols),
    .j         (scan_j),
    .const_v   (const_v),
    .dup_v     (dup_v),
    .dup_idx_v (dup_idx_v)
  );

  // Column stream; payload reads as zero whenever no column is offered.
  always_comb begin
    col.out_idx     = emit_idx;
    col.out_table   = '0;
    col.out_const   = 1'b0;
    col.out_dup     = 1'b0;
    col.out_dup_idx = '0;
    if (state == EMIT) begin
      col.out_table   = cols[emit_idx];
      col.out_const   = const_v[emit_idx];
      col.out_dup     = dup_v[emit_idx];
      col.out_dup_idx = dup_idx_v[emit_idx];
    end
  end
endmodule
